// File: rtl/answer_recorder.sv
// Buzzer-quiz question recorder: arms a question, locks the first buzzer and
// commits a 2-bit result per question into four per-player history lists.
module answer_recorder #(
  parameter int unsigned ANSWER_CYCLES = 500_000_000,
  parameter logic [2:0]  GAME_VIEW     = 3'd3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_view,
  input  logic        i_start,
  input  logic [3:0]  i_buzz,
  input  logic        i_judge_ok,
  input  logic        i_judge_ng,
  input  logic        i_clear,
  output logic [3:0]  o_play_count,
  output logic [17:0] o_player1_list,
  output logic [17:0] o_player2_list,
  output logic [17:0] o_player3_list,
  output logic [17:0] o_player4_list,
  output logic [2:0]  o_active_player,
  output logic        o_busy,
  output logic        o_round_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LOCKED = 2'd2} state_t;

  state_t             r_state;
  logic [31:0]        r_cnt;
  logic [3:0][17:0]   r_list;
  logic [3:0]         r_play_count;
  logic [2:0]         r_active;
  logic               r_busy;
  logic               r_round_full;

  logic               w_in_view;
  logic [2:0]         w_lock_player;
  logic               w_commit;
  logic               w_commit_all;
  logic [1:0]         w_code;
  logic [4:0]         w_idx;

  assign w_in_view = (i_view == GAME_VIEW);
  assign w_idx     = {r_play_count, 1'b0};

  // Lowest-indexed asserted buzzer wins a simultaneous buzz.
  always_comb begin
    w_lock_player = 3'd0;
    for (int k = 3; k >= 0; k--)
      if (i_buzz[k]) w_lock_player = 3'(k + 1);
  end

  always_comb begin
    w_commit     = 1'b0;
    w_commit_all = 1'b0;
    w_code       = 2'b00;
    if (w_in_view) begin
      case (r_state)
        ARMED: if (i_buzz == 4'd0 && i_judge_ng) begin
          w_commit     = 1'b1;
          w_commit_all = 1'b1;
        end
        LOCKED: begin
          if (i_judge_ok) begin
            w_commit = 1'b1;
            w_code   = 2'b01;
          end else if (i_judge_ng) begin
            w_commit = 1'b1;
            w_code   = 2'b10;
          end else if (r_cnt == ANSWER_CYCLES - 1) begin
            w_commit = 1'b1;
            w_code   = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state      <= IDLE;
      r_cnt        <= 32'd0;
      r_list       <= '0;
      r_play_count <= 4'd0;
      r_active     <= 3'd0;
      r_busy       <= 1'b0;
      r_round_full <= 1'b0;
    end else if (w_commit) begin
      for (int p = 0; p < 4; p++)
        if (w_commit_all || r_active == 3'(p + 1))
          r_list[p][w_idx +: 2] <= w_code;
      r_play_count <= r_play_count + 4'd1;
      r_round_full <= (r_play_count == 4'd8);
      r_active     <= 3'd0;
      r_busy       <= 1'b0;
      r_state      <= IDLE;
    end else if (w_in_view) begin
      case (r_state)
        IDLE: if (i_start && !r_round_full) begin
          r_state <= ARMED;
          r_busy  <= 1'b1;
        end
        ARMED: if (i_buzz != 4'd0) begin
          r_active <= w_lock_player;
          r_cnt    <= 32'd0;
          r_state  <= LOCKED;
        end
        LOCKED: r_cnt <= r_cnt + 32'd1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_play_count    = r_play_count;
  assign o_player1_list  = r_list[0];
  assign o_player2_list  = r_list[1];
  assign o_player3_list  = r_list[2];
  assign o_player4_list  = r_list[3];
  assign o_active_player = r_active;
  assign o_busy          = r_busy;
  assign o_round_full    = r_round_full;

endmodule

// File: doc/answer_recorder.md
# answer_recorder

Question-by-question result recorder for the buzzer quiz game. It runs one question at a time through a small state machine: the question is armed, the first player to buzz is locked in, and the host judges the answer or the answer window times out. Each finished question is committed as a 2-bit result code into four per-player 18-bit history lists and the question counter. The inspect-question view and the scoring logic downstream consume those lists and the counter directly.

## Interface
- ANSWER_CYCLES, 500_000_000: length of the answer window in clk cycles after a player locks in (5 s at 100 MHz).
- GAME_VIEW, 3: value of `view` in which the recorder accepts input.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- view  in  3  current UI view; inputs are ignored unless view == GAME_VIEW
- start  in  1  single-cycle pulse: host opens a new question
- buzz  in  4  single-cycle pulses, bit k = player k+1 buzzer
- judge_ok  in  1  single-cycle pulse: host accepts the answer
- judge_ng  in  1  single-cycle pulse: host rejects the answer, or skips while armed
- clear  in  1  single-cycle pulse: wipe the history (new game)
- play_count  out  4  number of committed questions, 0..9
- player1_list … player4_list  out  18 each  result history; question n (1..9) occupies bits [2n-1:2n-2]
- active_player  out  3  locked player 1..4; 0 = none
- busy  out  1  high in ARMED or LOCKED
- round_full  out  1  high when play_count == 9

## Operation
- Result codes: 00 = no answer or skipped, 01 = correct, 10 = wrong, 11 = timeout.
- At most one player's field is non-zero per question.
- States: IDLE(0), ARMED(1), LOCKED(2).
- IDLE: on `start` with round_full = 0 → ARMED. `start` is ignored while round_full = 1.
- ARMED, on any `buzz` bit:
  - Lock the lowest-indexed asserted player; active_player ← k+1.
  - Load the timeout counter with 0; → LOCKED.
  - This condition has priority over `judge_ng` in the same cycle.
- ARMED, on `judge_ng` with no buzz: commit 00 for all players → IDLE.
- ARMED, `judge_ok` alone: ignored.
- LOCKED:
  - `judge_ok` → commit 01 to the locked player.
  - `judge_ng` → commit 10.
  - Counter reaching ANSWER_CYCLES−1 → commit 11.
  - Priority when several occur in one cycle: judge_ok > judge_ng > timeout.
  - Further `buzz` pulses are ignored.
  - After any commit: active_player ← 0 → IDLE.
- Commit: write the code into field index play_count of the target list(s); play_count ← play_count + 1. No other bits change.
- `start` while ARMED or LOCKED: ignored.
- `clear` (any state, any view): lists ← 0, play_count ← 0, active_player ← 0, state ← IDLE. It has priority over every other event.
- view ≠ GAME_VIEW: all inputs except `clear` and `rst` are ignored.
  - State, counter and lists are held, so an in-progress question resumes when the view returns.
  - The timeout counter is frozen while the view is away.
- rst: same effect as `clear`; timeout counter ← 0.

## Timing
- All outputs are registered.
- Reset values: play_count 0, all lists 0, active_player 0, busy 0, round_full 0, state IDLE.
- Input pulse sampled at edge t → state and outputs updated at edge t (visible after edge t). Latency is 1 cycle.
- Timeout: the commit occurs exactly ANSWER_CYCLES cycles after the lock edge, counting only GAME_VIEW cycles.
- play_count saturates at 9: round_full blocks a 10th `start`, so no commit is possible at 9.
- Counter width is 32 bits; ANSWER_CYCLES must be < 2^32.

## Test plan
- Reset, then start, buzz=0100, judge_ok → player3_list = 0x00001, other lists 0, play_count 1, active_player 0, state IDLE.
- buzz=1010 in the same cycle (ANSWER_CYCLES=20) → active_player 2. With no judge input, 20 cycles later player2_list[1:0] = 11 and play_count = 1.
- 9 questions, each start+buzz=0001+judge_ng → player1_list = 0x2AAAA, play_count 9, round_full 1. A further start keeps busy 0.
- ARMED with judge_ng and buzz=0001 in the same cycle → LOCKED with active_player 1, no commit. A following judge_ok and judge_ng in the same cycle → code 01.
- LOCKED, view changed to 4 for 50 cycles (ANSWER_CYCLES=20) → no commit. Back in view 3 → timeout after the remaining cycles.
- 3 questions committed, then clear mid-LOCKED → all lists 0, play_count 0, active_player 0, IDLE next cycle. rst mid-ARMED gives the identical result.
